// File: rtl/audio_decimator.sv
// Block-average decimator: sums R = 2**LOG2_R input samples, emits the floored mean
// as a fixed-point word, and counts blocks dropped while the output is stalled.
module audio_decimator #(
    parameter int W_IN   = 16,
    parameter int LOG2_R = 6,
    parameter int FRAC   = 8,
    parameter int W_OUT  = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic signed [W_IN-1:0] x_data,
    input  logic                   x_valid,
    output logic                   x_ready,
    output logic [W_OUT-1:0]       y_data,
    output logic                   y_valid,
    input  logic                   y_ready,
    output logic [15:0]            overrun_count
);
    localparam int W_ACC = W_IN + LOG2_R;
    localparam int W_HI  = W_OUT - FRAC;

    generate
        if (W_OUT < W_IN + FRAC) begin : g_bad_width
            $error("audio_decimator: W_OUT must be >= W_IN + FRAC");
        end
    endgenerate

    logic signed [W_ACC-1:0] acc;
    logic signed [W_ACC-1:0] x_ext;
    logic signed [W_ACC-1:0] next_acc;
    logic [LOG2_R-1:0]       phase;
    logic signed [W_IN-1:0]  avg;
    logic signed [W_HI-1:0]  avg_ext;
    logic [W_OUT-1:0]        word;
    logic                    blk_done;
    logic                    out_free;

    assign x_ready  = 1'b1;
    assign x_ext    = W_ACC'(x_data);
    // Phase 0 starts a new block, so the previous sum is simply overwritten.
    assign next_acc = (phase == '0) ? x_ext : acc + x_ext;
    assign avg      = W_IN'(next_acc >>> LOG2_R);
    assign avg_ext  = W_HI'(avg);
    assign word     = {avg_ext, {FRAC{1'b0}}};
    assign blk_done = x_valid && (phase == '1);
    assign out_free = !y_valid || y_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            acc           <= '0;
            phase         <= '0;
            y_data        <= '0;
            y_valid       <= 1'b0;
            overrun_count <= '0;
        end else begin
            if (x_valid) begin
                acc   <= next_acc;
                phase <= phase + 1'b1;
            end

            if (blk_done && out_free) begin
                y_data  <= word;
                y_valid <= 1'b1;
            end else if (y_valid && y_ready) begin
                y_valid <= 1'b0;
            end

            // Input never stalls; a block finishing against a full register is lost.
            if (blk_done && !out_free && overrun_count != 16'hFFFF)
                overrun_count <= overrun_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_audio_decimator.sv
// Self-checking bench for audio_decimator: directed vector table, hand-built
// backpressure/reset sequences, and a randomized run against a block-average model.
module tb_audio_decimator;
    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic signed [15:0] x_data = '0;
    logic               x_valid = 1'b0;
    logic               x_ready;
    logic [31:0]        y_data;
    logic               y_valid;
    logic               y_ready = 1'b0;
    logic [15:0]        overrun_count;

    int total = 0;
    int bad   = 0;

    audio_decimator dut (
        .clk(clk), .reset(reset), .x_data(x_data), .x_valid(x_valid), .x_ready(x_ready),
        .y_data(y_data), .y_valid(y_valid), .y_ready(y_ready), .overrun_count(overrun_count)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of accepted samples and a one-deep output slot.
    longint      blk[$];
    logic        m_valid = 1'b0;
    logic [31:0] m_data  = '0;
    logic [15:0] m_ovr   = '0;

    function automatic logic [31:0] mk_word(longint sum);
        longint q;
        q = sum / 64;
        if ((sum % 64) != 0 && sum < 0) q = q - 1;
        return {q[23:0], 8'h00};
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step(bit rst, bit xv, logic signed [15:0] xd, bit yr);
        longint sum;
        bit     done;
        reset = rst; x_valid = xv; x_data = xd; y_ready = yr;
        #1;
        chk("x_ready", 64'(x_ready), 64'd1);
        done = 0;
        if (rst) begin
            blk.delete(); m_valid = 0; m_data = '0; m_ovr = '0;
        end else begin
            if (xv) begin
                blk.push_back(longint'(xd));
                if (blk.size() == 64) begin
                    sum = 0;
                    foreach (blk[i]) sum += blk[i];
                    blk.delete();
                    done = 1;
                end
            end
            if (done && (!m_valid || yr)) begin
                m_valid = 1; m_data = mk_word(sum);
            end else begin
                if (done && m_ovr != 16'hFFFF) m_ovr++;
                if (m_valid && yr) m_valid = 0;
            end
        end
        @(posedge clk);
        #1;
        chk("model_y_valid", 64'(y_valid), 64'(m_valid));
        if (m_valid || rst) chk("model_y_data", 64'(y_data), 64'(m_data));
        chk("model_overrun", 64'(overrun_count), 64'(m_ovr));
    endtask

    typedef struct {
        string              name;
        logic signed [15:0] fill;
        logic signed [15:0] last;
        logic [31:0]        exp;
    } vec_t;
    vec_t vecs[6];

    int n;

    initial begin
        vecs[0] = '{"dc_1000",  16'sd1000,   16'sd1000,   32'h0003E800};
        vecs[1] = '{"floor_m1", 16'sd0,      -16'sd1,     32'hFFFFFF00};
        vecs[2] = '{"floor_64", 16'sd0,      16'sd64,     32'h00000100};
        vecs[3] = '{"floor_63", 16'sd0,      16'sd63,     32'h00000000};
        vecs[4] = '{"max_pos",  16'sd32767,  16'sd32767,  32'h007FFF00};
        vecs[5] = '{"max_neg", -16'sd32768, -16'sd32768,  32'hFF800000};

        step(1, 1, 16'sd77, 1);
        chk("rst_y_valid", 64'(y_valid), 64'd0);
        chk("rst_y_data", 64'(y_data), 64'd0);
        chk("rst_overrun", 64'(overrun_count), 64'd0);

        foreach (vecs[v]) begin
            step(1, 0, 16'sd0, 1);
            for (int i = 0; i < 63; i++) step(0, 1, vecs[v].fill, 1);
            chk({vecs[v].name, "_early"}, 64'(y_valid), 64'd0);
            step(0, 1, vecs[v].last, 1);
            chk({vecs[v].name, "_valid"}, 64'(y_valid), 64'd1);
            chk({vecs[v].name, "_data"}, 64'(y_data), 64'(vecs[v].exp));
            step(0, 0, 16'sd0, 1);
            chk({vecs[v].name, "_one_cycle"}, 64'(y_valid), 64'd0);
        end

        // Backpressure: ramp 0..199 stalled, then drain and finish the fourth block.
        step(1, 0, 16'sd0, 0);
        for (int i = 0; i < 200; i++) begin
            step(0, 1, 16'(i), 0);
            if (i == 63) chk("bp_first_word", 64'(y_data), 64'h1F00);
            if (i == 191) chk("bp_overrun_192", 64'(overrun_count), 64'd2);
        end
        chk("bp_held_valid", 64'(y_valid), 64'd1);
        chk("bp_held_data", 64'(y_data), 64'h1F00);
        step(0, 0, 16'sd0, 1);
        chk("bp_drained", 64'(y_valid), 64'd0);
        for (int i = 200; i < 256; i++) step(0, 1, 16'(i), 1);
        chk("bp_next_valid", 64'(y_valid), 64'd1);
        chk("bp_next_data", 64'(y_data), 64'hDF00);
        chk("bp_overrun_final", 64'(overrun_count), 64'd2);

        // Output freed and reloaded on the same edge.
        step(1, 0, 16'sd0, 0);
        for (int i = 0; i < 64; i++) step(0, 1, 16'sd10, 0);
        for (int i = 0; i < 63; i++) step(0, 1, 16'sd20, 0);
        chk("sim_hold", 64'(y_data), 64'hA00);
        step(0, 1, 16'sd20, 1);
        chk("sim_valid", 64'(y_valid), 64'd1);
        chk("sim_data", 64'(y_data), 64'h1400);
        chk("sim_overrun", 64'(overrun_count), 64'd0);

        // Reset mid-block, then a gappy block of 100s.
        step(1, 0, 16'sd0, 1);
        for (int i = 0; i < 40; i++) step(0, 1, 16'sd5000, 1);
        step(1, 1, 16'sd5000, 1);
        n = 0;
        while (n < 64) begin
            if ($urandom_range(3) == 0) step(0, 0, 16'sd5000, 1);
            else begin
                step(0, 1, 16'sd100, 1);
                n++;
                if (n == 63) chk("rst_blk_early", 64'(y_valid), 64'd0);
            end
        end
        chk("rst_blk_valid", 64'(y_valid), 64'd1);
        chk("rst_blk_data", 64'(y_data), 64'h6400);
        chk("rst_blk_overrun", 64'(overrun_count), 64'd0);

        // Randomized traffic against the model.
        step(1, 0, 16'sd0, 0);
        for (int i = 0; i < 6000; i++)
            step($urandom_range(999) == 0, $urandom_range(3) != 0,
                 16'($urandom), $urandom_range(2) == 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
